// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// mem_ctrl_pkg : shared FSM encoding, lsb_op field layout and size helpers
//                for the byte-serialising memory controller.
// Revision 1.0
// =============================================================================
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int OP_STORE_BIT    = 3;
  localparam int OP_UNSIGNED_BIT = 2;
  localparam int OP_SIZE_HI      = 1;
  localparam int OP_SIZE_LO      = 0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] IO_REGION_DEF = 2'b11;

  // Index of the final byte of an access (nbytes - 1).
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 2'd0;
      SIZE_HALF: return 2'd1;
      default:   return 2'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_ext.sv
`default_nettype none
// =============================================================================
// mem_load_ext : combinational sign/zero extender for byte, half and word loads.
// Revision 1.0
// =============================================================================
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    case (size)
      SIZE_BYTE: ext = {{24{raw[7]  & ~is_unsigned}}, raw[7:0]};
      SIZE_HALF: ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// =============================================================================
// mem_ctrl : arbitrates LSB (priority) and fetch onto a byte-wide RAM port,
//            serialising 1/2/4-byte little-endian transfers.
// Build option: MEM_IO_STALL_EN holds IO-region writes while io_buffer_full.
// Revision 1.0
// =============================================================================
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter logic [1:0] IO_REGION = IO_REGION_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_flag,
  input  logic              lsb_req,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_data,
  input  logic [3:0]        lsb_op,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic        wr_q;
  logic        is_lsb;
  logic        tail;
  logic        uns;
  logic        prev_valid;
  logic        io_stall;
  logic [1:0]  cnt;
  logic [1:0]  last;
  logic [1:0]  prev_cnt;
  logic [1:0]  size;
  logic [23:0] sdata;
  logic [31:0] rbuf;
  logic [31:0] word;
  logic [31:0] ext_word;

`ifdef MEM_IO_STALL_EN
  assign io_stall = wr_q && (mem_a[17:16] == IO_REGION) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full ^ (^IO_REGION);
  assign io_stall  = 1'b0;
`endif

  assign mem_wr = wr_q && rdy_in && !io_stall;

  // Read data lags the address by one cycle; merge the byte arriving now.
  always_comb begin
    word = rbuf;
    word[{prev_cnt, 3'b000} +: 8] = mem_din;
  end

  mem_load_ext u_ext (
    .raw         (word),
    .size        (size),
    .is_unsigned (uns),
    .ext         (ext_word)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= S_IDLE;
      mem_a      <= '0;
      mem_dout   <= '0;
      wr_q       <= 1'b0;
      lsb_done   <= 1'b0;
      lsb_rdata  <= '0;
      if_done    <= 1'b0;
      if_inst    <= '0;
      is_lsb     <= 1'b0;
      tail       <= 1'b0;
      uns        <= 1'b0;
      cnt        <= '0;
      last       <= '0;
      size       <= '0;
      sdata      <= '0;
      rbuf       <= '0;
      prev_cnt   <= '0;
      prev_valid <= 1'b0;
    end else begin
      // Byte capture tracks the RAM pipeline even while paused, so no byte is lost.
      prev_valid <= (state == S_READ);
      prev_cnt   <= cnt;
      if (prev_valid) rbuf[{prev_cnt, 3'b000} +: 8] <= mem_din;

      if (rdy_in) begin
        case (state)
          S_IDLE: begin
            if (lsb_req) begin
              is_lsb <= 1'b1;
              mem_a  <= lsb_addr;
              cnt    <= '0;
              last   <= last_index(lsb_op[OP_SIZE_HI:OP_SIZE_LO]);
              size   <= lsb_op[OP_SIZE_HI:OP_SIZE_LO];
              uns    <= lsb_op[OP_UNSIGNED_BIT];
              tail   <= 1'b0;
              if (lsb_op[OP_STORE_BIT]) begin
                state    <= S_WRITE;
                wr_q     <= 1'b1;
                mem_dout <= lsb_data[7:0];
                sdata    <= lsb_data[31:8];
              end else begin
                state <= S_READ;
                wr_q  <= 1'b0;
              end
            end else if (if_req && !clear_flag) begin
              is_lsb <= 1'b0;
              mem_a  <= if_addr;
              cnt    <= '0;
              last   <= last_index(SIZE_WORD);
              size   <= SIZE_WORD;
              uns    <= 1'b1;
              state  <= S_READ;
              wr_q   <= 1'b0;
            end
          end

          S_READ: begin
            if (clear_flag) begin
              state <= S_IDLE;
              wr_q  <= 1'b0;
            end else begin
              if (cnt != last) begin
                mem_a <= mem_a + ADDR_ONE;
                cnt   <= cnt + 2'd1;
              end
              if (prev_valid && (prev_cnt == last)) begin
                state <= S_DONE;
                if (is_lsb) begin
                  lsb_done  <= 1'b1;
                  lsb_rdata <= ext_word;
                end else begin
                  if_done <= 1'b1;
                  if_inst <= word;
                end
              end
            end
          end

          // Stores ignore clear_flag; the trailing cycle matches read latency.
          S_WRITE: begin
            if (tail) begin
              state     <= S_DONE;
              lsb_done  <= 1'b1;
              lsb_rdata <= '0;
            end else if (!io_stall) begin
              if (cnt != last) begin
                mem_a    <= mem_a + ADDR_ONE;
                cnt      <= cnt + 2'd1;
                mem_dout <= sdata[7:0];
                sdata    <= {8'h00, sdata[23:8]};
              end else begin
                wr_q <= 1'b0;
                tail <= 1'b1;
              end
            end
          end

          default: begin
            lsb_done <= 1'b0;
            if_done  <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the load/store buffer, instruction fetch, and the byte-wide unified RAM port. Arbitrates one outstanding request at a time, with the LSB taking priority over fetch. Each access is serialised into 1/2/4 little-endian byte transfers. Loads are sign- or zero-extended, and the result is returned as a single-cycle done pulse to the winning requester.

## Interface
- Parameters:
- `ADDR_W`, default 32: address width.
- `IO_REGION`, default 2'b11: value of addr[17:16] that marks memory-mapped IO (0x30000 region).
- Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  pause; FSM frozen while low.
- `clear_flag`  in  1  pipeline flush.
- `lsb_req`  in  1  LSB request valid; held until `lsb_done` is seen.
- `lsb_addr`  in  32  byte address.
- `lsb_data`  in  32  store data (low bytes used).
- `lsb_op`  in  4  [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word).
- `lsb_done`  out  1  one-cycle completion pulse.
- `lsb_rdata`  out  32  extended load data; 0 for stores.
- `if_req`  in  1  fetch request; held until `if_done`.
- `if_addr`  in  32  fetch address, word access.
- `if_done`  out  1  one-cycle completion pulse.
- `if_inst`  out  32  fetched word.
- `mem_din`  in  8  RAM read byte; reflects the `mem_a` of the previous cycle.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  UART TX buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
- If `lsb_req`: latch the LSB request, ignoring `if_req` that cycle.
- Else if `if_req` and not `clear_flag`: latch fetch as a word read.
- On acceptance: `mem_a` = addr, byte counter cnt = 0, nbytes = 1/2/4.
- Loads and fetches go to READ with `mem_wr` = 0.
- Stores go to WRITE with `mem_dout` = data[7:0] and `mem_wr` = 1.
- READ, each cycle:
- Capture `mem_din` into result byte cnt.
- If cnt < nbytes−1: `mem_a` += 1, cnt += 1.
- Else go to DONE.
- WRITE, each cycle:
- If cnt < nbytes−1: `mem_a` += 1, `mem_dout` = byte cnt+1, cnt += 1.
- Else `mem_wr` = 0 and go to DONE.
- DONE: the winning done output is high for exactly this cycle, then IDLE. Requests are ignored in DONE, so a request still held from the finished access cannot be re-accepted.
- Load extension: byte/half sign-extend from bit 7/15 unless `lsb_op[2]`; word unchanged. Store result: `lsb_rdata` = 0.
- `clear_flag`:
- An in-flight fetch or load is aborted: return to IDLE, no done pulse, `mem_wr` = 0.
- An in-flight store always completes, done pulse included, because stores are already committed.
- A flush arriving in the same cycle as a new `if_req` rejects the fetch.
- `rdy_in` low: state, counters and outputs hold. `mem_wr` is gated to 0 for that cycle, and the byte is re-issued after resume.
- Address arithmetic is 32-bit wrap-around; 0xFFFFFFFF+1 = 0.

## Timing
- Reset values: `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `lsb_done`=0, `lsb_rdata`=0, `if_done`=0, `if_inst`=0, state IDLE.
- A request sampled at edge E0 gives done high during the cycle after edge E0+N+1, for N bytes.
- Word read: done is high 5 cycles after acceptance. Byte read: 2 cycles.
- Writes have the same latency.
- The requester must hold `req` and its operands stable from assertion until it samples done. The minimum gap between accepted requests is 1 cycle (DONE).

## Configuration
- `MEM_IO_STALL_EN` defined:
- In WRITE, when `mem_a[17:16]` == `IO_REGION` and `io_buffer_full` = 1, the byte is held: `mem_wr` = 0, no advance.
- The write resumes the cycle after `io_buffer_full` drops.
- Undefined: `io_buffer_full` is ignored and IO writes proceed at full rate.

## Structure
- Shared package constants:
- FSM state encoding.
- `lsb_op` field positions and size codes.
- IO region constant.
- Sub-module: `mem_load_ext`, a combinational size/sign extender used for `lsb_rdata`.
- Everything else is a single FSM module.

## Test plan
- Store-word path: `lsb_req`, store word 0xDEADBEEF to 0x100, then `lsb_req` load word from 0x100.
- Writes: bytes EF, BE, AD, DE at 0x100–0x103.
- `lsb_done` pulses once per access.
- `lsb_rdata` = 0xDEADBEEF, 5 cycles after acceptance.
- Load extension: memory byte 0x80 at 0x200. Signed byte load gives 0xFFFFFF80; unsigned byte load gives 0x00000080.
- Arbitration: `if_req`(0x0) and `lsb_req`(load 0x40) rise in the same cycle. The LSB access is served first, then fetch. Exactly one `if_done` and one `lsb_done`, with no duplicate access in DONE.
- Flush: `clear_flag` during the 2nd byte of a fetch gives no `if_done` and IDLE on the next cycle. `clear_flag` during a store word: all 4 bytes written and `lsb_done` pulses.
- IO stall (macro on): store byte to 0x30000 with `io_buffer_full` = 1 for 3 cycles. `mem_wr` stays 0 for 3 cycles, then one write; `lsb_done` 3 cycles later than nominal.
- Reset and pause:
- Assert `rst_in` = 0 mid word-read: all outputs return to reset values immediately (async).
- `rdy_in` = 0 for 2 cycles mid-read: result unchanged, latency +2.
